mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single word-addressed memory port (30-bit word address, 4-bit byte write enable, combinational read data) between two requesters.
- Master 0 is the cpu core; master 1 is a DMA/debug requester.
- Round-robin arbitration with a lock input, so a master can hold the port across consecutive cycles (e.g. the two halves of a misaligned load/store).
- Sits between the requesters and the memory model/RAM; adds one cycle of grant latency when ownership changes.

Parameters:
- MAX_LOCK, 4: maximum consecutive cycles a locked owner keeps the port while the other master waits; minimum 1.
- STAT_WIDTH, 16: width of statistics counters (optional feature only).

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  reset, synchronous, active-low
- m0_req  input  1  master 0 requests an access this cycle
- m0_lock  input  1  master 0 wants to keep ownership next cycle
- m0_address  input  30  master 0 word address [31:2]
- m0_wdata  input  32  master 0 write data
- m0_write_enable  input  4  master 0 byte write enables
- m0_gnt  output  1  master 0 access performed this cycle
- m0_rdata  output  32  read data to master 0
- m1_req, m1_lock, m1_address, m1_wdata, m1_write_enable, m1_gnt, m1_rdata: same as master 0, for master 1
- mem_address  output  30  word address to memory
- mem_in  output  32  write data to memory
- mem_write_enable  output  4  byte write enables to memory
- mem_out  input  32  memory read data, combinational from mem_address

Behaviour:
- State: owner ∈ {NONE, M0, M1}; last_served ∈ {M0, M1}; lock_count [ceil(log2(MAX_LOCK+1))-1:0].
- Reset (rst==0 at posedge):
  - owner=NONE, last_served=M1 (so M0 wins the first tie), lock_count=0.
  - While rst==0: m0_gnt=m1_gnt=0, mem_write_enable=0.
- Combinational:
  - gnt_k = rst & (owner==Mk) & mk_req.
  - mem_address and mem_in are muxed from the owner; when owner is NONE they come from m0.
  - mem_write_enable = gnt of owner ? owner's write_enable : 4'b0. No write ever reaches memory without a grant.
  - m0_rdata = m1_rdata = mem_out. Data is valid only when the matching gnt is high.
- A master's access completes in the cycle its gnt is high. It must hold req, address, data and enables stable until then.
- Next owner at posedge, when rst==1:
  - Locked hold: owner==Mk, mk_req, mk_lock and lock_count < MAX_LOCK-1 → keep owner, lock_count+1.
  - Otherwise re-arbitrate with lock_count=0:
    - both requesting → the master != last_served;
    - one requesting → that master;
    - none → NONE.
  - Lock is only honoured when the owner both requested and was granted in that cycle. lock with req=0 is ignored.
  - last_served updates to the current owner on every cycle where a gnt is high.
- Latency:
  - A request arriving while owner==NONE or owner==other is granted no earlier than the next cycle.
  - A lone requester that keeps req high keeps the port back-to-back (one access per cycle).
- Fairness: with both masters requesting and no lock, grants strictly alternate. With lock, the waiting master is granted within MAX_LOCK+1 cycles.
- Owner drops req: that cycle gives no gnt and no write; next edge re-arbitrates.
- Reset mid-access: a pending locked sequence is abandoned; owner=NONE on the following cycle.

Optional Feature:
- Macro: MEM_ARB_STATS_EN.
- Defined — adds these outputs:
  - stat_m0_grants [STAT_WIDTH-1:0]: cycles with m0_gnt.
  - stat_m1_grants [STAT_WIDTH-1:0]: cycles with m1_gnt.
  - stat_conflicts [STAT_WIDTH-1:0]: cycles where both reqs are high and exactly one gnt is high.
  - Counters increment at posedge, saturate at all-ones, and clear on reset.
- Undefined: these ports and registers do not exist; arbitration behaviour is identical.

Test Plan:
- Reset, then m0_req=1 with address 30'h100 and write_enable 4'b0011 → cycle 1: m0_gnt=0, mem_write_enable=0; cycle 2 onward: m0_gnt=1, mem_address=30'h100, mem_write_enable=4'b0011.
- Both req high continuously, no lock, from idle after reset → grants go M0, M1, M0, M1… each gnt high for exactly one cycle.
- M0 owns with m0_lock=1 and m1_req=1, MAX_LOCK=4 → M0 gets 4 consecutive gnts, then M1 is granted on the 5th cycle.
- M1 writes 4'b1111 with data 32'hDEADBEEF while m0_req=0; next cycle M1 reads the same address → m1_rdata=32'hDEADBEEF and m0_gnt stays 0.
- rst driven low for one cycle while M1 holds a lock → that cycle has mem_write_enable=0 and no gnt; next cycle owner is NONE and a tie goes to M0.
- With MEM_ARB_STATS_EN: 6 cycles of alternating dual requests → stat_m0_grants=3, stat_m1_grants=3, stat_conflicts=6.

Source files
------------

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter
//  Purpose  : Shares one word-addressed memory port between two requesters.
//             Master 0 is the CPU core, master 1 is a DMA/debug requester.
//             Arbitration is round-robin. A granted owner may assert lock to
//             keep the port for up to MAX_LOCK consecutive cycles while the
//             other master waits. A change of ownership costs one cycle.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    MAX_LOCK   : max consecutive locked cycles for one owner (>= 1)
//    STAT_WIDTH : statistics counter width (only with MEM_ARB_STATS_EN)
//  Ports
//    clk, rst                : clock (rising edge), sync active-low reset
//    mN_req / mN_lock        : access request / keep ownership next cycle
//    mN_address/_wdata/_write_enable : word address, write data, byte enables
//    mN_gnt                  : access performed this cycle
//    mN_rdata                : read data, valid while mN_gnt is high
//    mem_address/_in/_write_enable   : memory-side request
//    mem_out                 : memory read data (combinational)
//    stat_*                  : saturating statistics counters, present only
//                              when MEM_ARB_STATS_EN is defined
//  Optional feature macro : MEM_ARB_STATS_EN
// ============================================================================
module mem_arbiter #(
    parameter int MAX_LOCK   = 4
`ifdef MEM_ARB_STATS_EN
    ,
    parameter int STAT_WIDTH = 16
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  m0_req,
    input  logic                  m0_lock,
    input  logic [29:0]           m0_address,
    input  logic [31:0]           m0_wdata,
    input  logic [3:0]            m0_write_enable,
    output logic                  m0_gnt,
    output logic [31:0]           m0_rdata,
    input  logic                  m1_req,
    input  logic                  m1_lock,
    input  logic [29:0]           m1_address,
    input  logic [31:0]           m1_wdata,
    input  logic [3:0]            m1_write_enable,
    output logic                  m1_gnt,
    output logic [31:0]           m1_rdata,
`ifdef MEM_ARB_STATS_EN
    output logic [STAT_WIDTH-1:0] stat_m0_grants,
    output logic [STAT_WIDTH-1:0] stat_m1_grants,
    output logic [STAT_WIDTH-1:0] stat_conflicts,
`endif
    output logic [29:0]           mem_address,
    output logic [31:0]           mem_in,
    output logic [3:0]            mem_write_enable,
    input  logic [31:0]           mem_out
);

    localparam int               c_LCW        = $clog2(MAX_LOCK + 1);
    localparam logic [c_LCW-1:0] c_LOCK_LIMIT = c_LCW'(MAX_LOCK - 1);

    // Owner encoding
    localparam logic [1:0] c_OWN_NONE = 2'd0;
    localparam logic [1:0] c_OWN_M0   = 2'd1;
    localparam logic [1:0] c_OWN_M1   = 2'd2;

    logic [1:0]       r_owner;
    logic             r_last_served;   // 0 = M0, 1 = M1
    logic [c_LCW-1:0] r_lock_count;

    logic             w_gnt0;
    logic             w_gnt1;
    logic             w_last_eff;
    logic             w_hold;
    logic [1:0]       w_arb_owner;

    // A grant needs ownership and a live request; reset masks everything.
    assign w_gnt0 = rst & (r_owner == c_OWN_M0) & m0_req;
    assign w_gnt1 = rst & (r_owner == c_OWN_M1) & m1_req;

    assign m0_gnt   = w_gnt0;
    assign m1_gnt   = w_gnt1;
    assign m0_rdata = mem_out;
    assign m1_rdata = mem_out;

    // Address/data follow the owner; with no owner they come from master 0.
    assign mem_address = (r_owner == c_OWN_M1) ? m1_address : m0_address;
    assign mem_in      = (r_owner == c_OWN_M1) ? m1_wdata   : m0_wdata;

    always_comb begin
        mem_write_enable = 4'b0000;
        if (w_gnt0) begin
            mem_write_enable = m0_write_enable;
        end else if (w_gnt1) begin
            mem_write_enable = m1_write_enable;
        end
    end

    // The round-robin decision must see this cycle's grant, otherwise a
    // master served now would still look "not last served" at this edge
    // and win the next tie too.
    assign w_last_eff = w_gnt1 ? 1'b1 : (w_gnt0 ? 1'b0 : r_last_served);

    // Lock only extends an ownership that actually produced a grant.
    assign w_hold = ((w_gnt0 & m0_lock) | (w_gnt1 & m1_lock))
                    & (r_lock_count < c_LOCK_LIMIT);

    always_comb begin
        w_arb_owner = c_OWN_NONE;
        if (m0_req && m1_req) begin
            w_arb_owner = w_last_eff ? c_OWN_M0 : c_OWN_M1;
        end else if (m0_req) begin
            w_arb_owner = c_OWN_M0;
        end else if (m1_req) begin
            w_arb_owner = c_OWN_M1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_owner       <= c_OWN_NONE;
            r_last_served <= 1'b1;          // M0 wins the first tie
            r_lock_count  <= '0;
        end else begin
            if (w_gnt0 || w_gnt1) begin
                r_last_served <= w_last_eff;
            end
            if (w_hold) begin
                r_lock_count <= r_lock_count + c_LCW'(1);
            end else begin
                r_lock_count <= '0;
                r_owner      <= w_arb_owner;
            end
        end
    end

`ifdef MEM_ARB_STATS_EN
    logic w_conflict;

    // Both want the port and exactly one got it.
    assign w_conflict = m0_req & m1_req & (w_gnt0 ^ w_gnt1);

    always_ff @(posedge clk) begin
        if (!rst) begin
            stat_m0_grants <= '0;
            stat_m1_grants <= '0;
            stat_conflicts <= '0;
        end else begin
            if (w_gnt0 && (stat_m0_grants != '1)) begin
                stat_m0_grants <= stat_m0_grants + STAT_WIDTH'(1);
            end
            if (w_gnt1 && (stat_m1_grants != '1)) begin
                stat_m1_grants <= stat_m1_grants + STAT_WIDTH'(1);
            end
            if (w_conflict && (stat_conflicts != '1)) begin
                stat_conflicts <= stat_conflicts + STAT_WIDTH'(1);
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_arbiter
//  Purpose  : Self-checking bench for mem_arbiter. A behavioural model of
//             ownership/round-robin/lock plus a reference memory predicts
//             every output each cycle; directed scenarios add literal checks.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int c_ML = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_lock, m1_req, m1_lock;
    logic [29:0] m0_address, m1_address;
    logic [31:0] m0_wdata, m1_wdata;
    logic [3:0]  m0_write_enable, m1_write_enable;
    logic        m0_gnt, m1_gnt;
    logic [31:0] m0_rdata, m1_rdata;
    logic [29:0] mem_address;
    logic [31:0] mem_in;
    logic [3:0]  mem_write_enable;
    logic [31:0] mem_out = 32'h0;
`ifdef MEM_ARB_STATS_EN
    logic [15:0] stat_m0_grants, stat_m1_grants, stat_conflicts;
`endif

    always #5 clk = ~clk;

    mem_arbiter #(.MAX_LOCK(c_ML)) u_dut (
        .clk              (clk),
        .rst              (rst),
        .m0_req           (m0_req),
        .m0_lock          (m0_lock),
        .m0_address       (m0_address),
        .m0_wdata         (m0_wdata),
        .m0_write_enable  (m0_write_enable),
        .m0_gnt           (m0_gnt),
        .m0_rdata         (m0_rdata),
        .m1_req           (m1_req),
        .m1_lock          (m1_lock),
        .m1_address       (m1_address),
        .m1_wdata         (m1_wdata),
        .m1_write_enable  (m1_write_enable),
        .m1_gnt           (m1_gnt),
        .m1_rdata         (m1_rdata),
`ifdef MEM_ARB_STATS_EN
        .stat_m0_grants   (stat_m0_grants),
        .stat_m1_grants   (stat_m1_grants),
        .stat_conflicts   (stat_conflicts),
`endif
        .mem_address      (mem_address),
        .mem_in           (mem_in),
        .mem_write_enable (mem_write_enable),
        .mem_out          (mem_out)
    );

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] we);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (we[b]) r[b*8 +: 8] = d[b*8 +: 8];
        end
        return r;
    endfunction

    // Memory seen by the DUT (written from DUT outputs) and reference memory
    // (written from the model's predicted accesses).
    logic [31:0] bmem [256];
    logic [31:0] rmem [256];

    always @(posedge clk) begin
        if (mem_write_enable != 4'b0000)
            bmem[mem_address[7:0]] <= merge(bmem[mem_address[7:0]], mem_in, mem_write_enable);
    end

    always @(negedge clk) mem_out <= bmem[mem_address[7:0]];

    // ---------------- behavioural model ----------------
    int mo_owner = -1;   // -1 none, 0 or 1 = master index
    int mo_last  = 1;    // master served most recently
    int mo_run   = 0;    // extra locked cycles already taken in current run

    function automatic int granted();
        if (rst === 1'b1 && mo_owner == 0 && m0_req === 1'b1) return 0;
        if (rst === 1'b1 && mo_owner == 1 && m1_req === 1'b1) return 1;
        return -1;
    endfunction

    always @(posedge clk) begin : model
        int  g;
        bit  lk;
        g = granted();
        if (rst !== 1'b1) begin
            mo_owner = -1;
            mo_last  = 1;
            mo_run   = 0;
        end else begin
            if (g == 0) rmem[m0_address[7:0]] = merge(rmem[m0_address[7:0]], m0_wdata, m0_write_enable);
            if (g == 1) rmem[m1_address[7:0]] = merge(rmem[m1_address[7:0]], m1_wdata, m1_write_enable);
            if (g >= 0) mo_last = g;
            lk = (g == 0) ? m0_lock : (g == 1) ? m1_lock : 1'b0;
            if (g >= 0 && lk && (mo_run + 1) < c_ML) begin
                mo_run++;
            end else begin
                mo_run = 0;
                if (m0_req && m1_req) mo_owner = 1 - mo_last;
                else if (m0_req)      mo_owner = 0;
                else if (m1_req)      mo_owner = 1;
                else                  mo_owner = -1;
            end
        end
        chk_en = 1'b1;
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin : compare
        int g;
        #1;
        if (chk_en) begin
            g = granted();
            check("m0_gnt", {31'b0, m0_gnt}, {31'b0, g == 0});
            check("m1_gnt", {31'b0, m1_gnt}, {31'b0, g == 1});
            check("mem_address", {2'b0, mem_address}, {2'b0, (mo_owner == 1) ? m1_address : m0_address});
            check("mem_in", mem_in, (mo_owner == 1) ? m1_wdata : m0_wdata);
            check("mem_we", {28'b0, mem_write_enable},
                  {28'b0, (g == 0) ? m0_write_enable : (g == 1) ? m1_write_enable : 4'b0});
            if (g == 0) check("m0_rdata", m0_rdata, rmem[m0_address[7:0]]);
            if (g == 1) check("m1_rdata", m1_rdata, rmem[m1_address[7:0]]);
        end
    end

    // ---------------- stimulus ----------------
    task automatic nxt();
        @(posedge clk); #1;
    endtask

    task automatic smp();
        @(negedge clk); #3;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            bmem[i] = 32'h5A5A_0000 | i;
            rmem[i] = 32'h5A5A_0000 | i;
        end
        rst = 1'b0;
        m0_req = 1'b1; m0_lock = 1'b0; m0_address = 30'h100;
        m0_wdata = 32'h1122_3344; m0_write_enable = 4'b0011;
        m1_req = 1'b0; m1_lock = 1'b0; m1_address = 30'h0;
        m1_wdata = 32'h0; m1_write_enable = 4'b0;

        // Reset, then single write-requester with one cycle of grant latency
        nxt();
        smp();
        check("rst_m0_gnt", {31'b0, m0_gnt}, 32'd0);
        check("rst_we", {28'b0, mem_write_enable}, 32'd0);
        nxt();
        rst = 1'b1;
        smp();
        check("lat_c1_gnt", {31'b0, m0_gnt}, 32'd0);
        check("lat_c1_we", {28'b0, mem_write_enable}, 32'd0);
        nxt();
        smp();
        check("lat_c2_gnt", {31'b0, m0_gnt}, 32'd1);
        check("lat_c2_addr", {2'b0, mem_address}, 32'h100);
        check("lat_c2_we", {28'b0, mem_write_enable}, 32'h3);
        nxt();
        smp();
        check("b2b_gnt", {31'b0, m0_gnt}, 32'd1);
        nxt();
        m0_req = 1'b0; m0_write_enable = 4'b0;
        smp();
        check("drop_gnt", {31'b0, m0_gnt}, 32'd0);

        // Both request from idle after reset: strict alternation M0,M1,...
        nxt();
        rst = 1'b0;
        smp();
        nxt();
        rst = 1'b1;
        m0_req = 1'b1; m1_req = 1'b1;
        m0_address = 30'h10; m1_address = 30'h20;
        smp();
        check("alt_idle_m0", {31'b0, m0_gnt}, 32'd0);
        check("alt_idle_m1", {31'b0, m1_gnt}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            nxt();
            smp();
            check("alt_m0", {31'b0, m0_gnt}, {31'b0, (i % 2) == 0});
            check("alt_m1", {31'b0, m1_gnt}, {31'b0, (i % 2) == 1});
        end

        // M0 locks with M1 waiting: 4 M0 grants then M1 on the 5th cycle
        nxt();
        m0_lock = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) nxt();
            smp();
            check("lock_m0", {31'b0, m0_gnt}, {31'b0, i < 4});
            check("lock_m1", {31'b0, m1_gnt}, {31'b0, i == 4});
        end

        // M1 writes DEADBEEF then reads it back
        nxt();
        m0_lock = 1'b0; m0_req = 1'b0;
        m1_address = 30'h55; m1_wdata = 32'hDEAD_BEEF; m1_write_enable = 4'b1111;
        smp();
        check("wr_wait_m1", {31'b0, m1_gnt}, 32'd0);
        nxt();
        smp();
        check("wr_m1_gnt", {31'b0, m1_gnt}, 32'd1);
        check("wr_we", {28'b0, mem_write_enable}, 32'hF);
        check("wr_addr", {2'b0, mem_address}, 32'h55);
        nxt();
        m1_write_enable = 4'b0; m1_wdata = 32'h0;
        smp();
        check("rd_m1_gnt", {31'b0, m1_gnt}, 32'd1);
        check("rd_data", m1_rdata, 32'hDEAD_BEEF);
        check("rd_m0_gnt", {31'b0, m0_gnt}, 32'd0);

        // Reset during an M1 locked sequence
        nxt();
        m1_lock = 1'b1; m0_req = 1'b1;
        m1_write_enable = 4'b1111; m1_wdata = 32'hCAFE_F00D;
        smp();
        check("lk_m1_gnt", {31'b0, m1_gnt}, 32'd1);
        nxt();
        rst = 1'b0;
        smp();
        check("mrst_we", {28'b0, mem_write_enable}, 32'd0);
        check("mrst_m1", {31'b0, m1_gnt}, 32'd0);
        check("mrst_m0", {31'b0, m0_gnt}, 32'd0);
        nxt();
        rst = 1'b1;
        smp();
        check("post_m0", {31'b0, m0_gnt}, 32'd0);
        check("post_m1", {31'b0, m1_gnt}, 32'd0);
        nxt();
        smp();
        check("tie_m0", {31'b0, m0_gnt}, 32'd1);
        check("tie_m1", {31'b0, m1_gnt}, 32'd0);

`ifdef MEM_ARB_STATS_EN
        // Six cycles of alternating dual requests from a fresh reset
        nxt();
        rst = 1'b0; m1_lock = 1'b0; m1_write_enable = 4'b0;
        smp();
        nxt();
        rst = 1'b1;
        smp();
        for (int i = 0; i < 6; i++) begin
            nxt();
            smp();
        end
        nxt();
        m0_req = 1'b0; m1_req = 1'b0;
        smp();
        check("stat_m0", {16'b0, stat_m0_grants}, 32'd3);
        check("stat_m1", {16'b0, stat_m1_grants}, 32'd3);
        check("stat_conf", {16'b0, stat_conflicts}, 32'd6);
`endif

        nxt();
        m0_req = 1'b0; m1_req = 1'b0; m1_lock = 1'b0; m1_write_enable = 4'b0;
        nxt();
        nxt();
        smp();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
